// File: rtl/sdio_cmd_sequencer.sv
// rtl/sdio_cmd_sequencer.sv - SDIO command-layer sequencer: card state/RCA, CMD52 register access, CMD53 data launch
module sdio_cmd_sequencer #(
   parameter logic [15:0] DEFAULT_RCA = 16'h0001,
   parameter logic [2:0]  NUM_FUNCS   = 3'd1,
   parameter logic [7:0]  REG_TIMEOUT = 8'd64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cmd_stb,
   input  logic        i_cmd_crc_good_stb,
   input  logic [5:0]  i_cmd,
   input  logic [31:0] i_cmd_arg,
   input  logic        i_rsps_idle,
   output logic        o_rsps_stb,
   output logic [39:0] o_rsps,
   output logic [7:0]  o_rsps_len,
   output logic        o_rsps_fail,
   output logic        o_data_activate,
   input  logic        i_data_finished,
   output logic        o_write_flag,
   output logic [12:0] o_data_count,
   output logic        o_reg_stb,
   output logic        o_reg_write,
   output logic [2:0]  o_reg_func,
   output logic [16:0] o_reg_addr,
   output logic [7:0]  o_reg_wdata,
   input  logic        i_reg_ack,
   input  logic [7:0]  i_reg_rdata,
   input  logic [23:0] i_ocr,
   output logic [1:0]  o_card_state,
   output logic [15:0] o_rca,
   output logic [7:0]  o_crc_err_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_REG_WAIT, S_RESPOND, S_RSP_WAIT, S_DATA
   } state_e;

   localparam logic [1:0] CARD_INIT = 2'd0;
   localparam logic [1:0] CARD_STBY = 2'd1;
   localparam logic [1:0] CARD_CMD  = 2'd2;

   state_e      state_q, state_d;
   logic [5:0]  cmd_idx_q, cmd_idx_d;
   logic [31:0] cmd_arg_q, cmd_arg_d;
   logic [1:0]  card_q, card_d;
   logic [15:0] rca_q, rca_d;
   logic [7:0]  crc_cnt_q, crc_cnt_d;
   logic [39:0] rsps_q, rsps_d;
   logic        rsps_stb_q, rsps_stb_d;
   logic        rsps_fail_q, rsps_fail_d;
   logic [12:0] dcount_q, dcount_d;
   logic        wflag_q, wflag_d;
   logic        pend_q, pend_d;
   logic        reg_stb_q, reg_stb_d;
   logic        reg_write_q, reg_write_d;
   logic [2:0]  reg_func_q, reg_func_d;
   logic [16:0] reg_addr_q, reg_addr_d;
   logic [7:0]  reg_wdata_q, reg_wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        act_q, act_d;
   logic        unused_op_code;

   // CMD53 op-code (incrementing address) is the data PHY's concern, not ours
   assign unused_op_code = cmd_arg_q[26];

   function automatic logic [39:0] r5(input logic [5:0] idx, input logic [7:0] flags,
                                      input logic [7:0] data);
      return {2'b00, idx, 16'h0000, flags, data};
   endfunction

   always_comb begin
      state_d     = state_q;
      cmd_idx_d   = cmd_idx_q;
      cmd_arg_d   = cmd_arg_q;
      card_d      = card_q;
      rca_d       = rca_q;
      crc_cnt_d   = crc_cnt_q;
      rsps_d      = rsps_q;
      rsps_stb_d  = 1'b0;
      rsps_fail_d = 1'b0;
      dcount_d    = dcount_q;
      wflag_d     = wflag_q;
      pend_d      = pend_q;
      reg_stb_d   = 1'b0;
      reg_write_d = reg_write_q;
      reg_func_d  = reg_func_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      cnt_d       = cnt_q;
      act_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_cmd_stb) begin
               if (!i_cmd_crc_good_stb) begin
                  rsps_fail_d = 1'b1;
                  if (crc_cnt_q != 8'hFF) crc_cnt_d = crc_cnt_q + 8'd1;
               end else begin
                  cmd_idx_d = i_cmd;
                  cmd_arg_d = i_cmd_arg;
                  state_d   = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            state_d = S_IDLE;
            case (cmd_idx_q)
               6'd0: begin
                  card_d      = CARD_INIT;
                  rca_d       = 16'h0000;
                  rsps_fail_d = 1'b1;
               end
               6'd5: begin
                  rsps_d  = {2'b00, 6'h3F, 1'b1, NUM_FUNCS, 1'b0, 3'b000, i_ocr};
                  state_d = S_RESPOND;
               end
               6'd3: begin
                  if (card_q != CARD_CMD) begin
                     rca_d   = DEFAULT_RCA;
                     card_d  = CARD_STBY;
                     rsps_d  = {2'b00, 6'd3, DEFAULT_RCA, 16'h0000};
                     state_d = S_RESPOND;
                  end else begin
                     rsps_fail_d = 1'b1;
                  end
               end
               6'd7: begin
                  if (cmd_arg_q[31:16] == rca_q && rca_q != 16'h0000) begin
                     card_d  = CARD_CMD;
                     rsps_d  = {2'b00, 6'd7, 19'b0, 4'd4, 9'b0};
                     state_d = S_RESPOND;
                  end else begin
                     card_d      = CARD_STBY;
                     rsps_fail_d = 1'b1;
                  end
               end
               6'd52: begin
                  if (card_q == CARD_CMD) begin
                     reg_write_d = cmd_arg_q[31];
                     reg_func_d  = cmd_arg_q[30:28];
                     reg_addr_d  = cmd_arg_q[25:9];
                     reg_wdata_d = cmd_arg_q[7:0];
                     reg_stb_d   = 1'b1;
                     cnt_d       = 8'd0;
                     state_d     = S_REG_WAIT;
                  end else begin
                     rsps_fail_d = 1'b1;
                  end
               end
               6'd53: begin
                  if (card_q == CARD_CMD) begin
                     if (cmd_arg_q[27]) begin
                        rsps_d = r5(cmd_idx_q, 8'h40, 8'h00);
                     end else begin
                        dcount_d = (cmd_arg_q[8:0] == 9'd0) ? 13'd512 : {4'd0, cmd_arg_q[8:0]};
                        wflag_d  = cmd_arg_q[31];
                        rsps_d   = r5(cmd_idx_q, 8'h20, 8'h00);
                        pend_d   = 1'b1;
                     end
                     state_d = S_RESPOND;
                  end else begin
                     rsps_fail_d = 1'b1;
                  end
               end
               default: rsps_fail_d = 1'b1;
            endcase
         end
         S_REG_WAIT: begin
            // The counter idles during the request cycle, so a timeout lands REG_TIMEOUT+1 cycles after o_reg_stb
            if (i_reg_ack) begin
               rsps_d  = r5(cmd_idx_q, 8'h20, i_reg_rdata);
               state_d = S_RESPOND;
            end else if (!reg_stb_q && cnt_q == REG_TIMEOUT - 8'd1) begin
               rsps_d  = r5(cmd_idx_q, 8'h28, 8'h00);
               state_d = S_RESPOND;
            end else begin
               cnt_d = reg_stb_q ? 8'd0 : cnt_q + 8'd1;
            end
         end
         S_RESPOND: state_d = S_RSP_WAIT;
         S_RSP_WAIT: begin
            if (i_rsps_idle) begin
               if (pend_q) begin
                  pend_d  = 1'b0;
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (i_data_finished) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      rsps_stb_d = (state_d == S_RESPOND);
      act_d      = (state_d == S_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_idx_q   <= 6'd0;
         cmd_arg_q   <= 32'd0;
         card_q      <= CARD_INIT;
         rca_q       <= 16'h0000;
         crc_cnt_q   <= 8'd0;
         rsps_q      <= 40'd0;
         rsps_stb_q  <= 1'b0;
         rsps_fail_q <= 1'b0;
         dcount_q    <= 13'd0;
         wflag_q     <= 1'b0;
         pend_q      <= 1'b0;
         reg_stb_q   <= 1'b0;
         reg_write_q <= 1'b0;
         reg_func_q  <= 3'd0;
         reg_addr_q  <= 17'd0;
         reg_wdata_q <= 8'd0;
         cnt_q       <= 8'd0;
         act_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_idx_q   <= cmd_idx_d;
         cmd_arg_q   <= cmd_arg_d;
         card_q      <= card_d;
         rca_q       <= rca_d;
         crc_cnt_q   <= crc_cnt_d;
         rsps_q      <= rsps_d;
         rsps_stb_q  <= rsps_stb_d;
         rsps_fail_q <= rsps_fail_d;
         dcount_q    <= dcount_d;
         wflag_q     <= wflag_d;
         pend_q      <= pend_d;
         reg_stb_q   <= reg_stb_d;
         reg_write_q <= reg_write_d;
         reg_func_q  <= reg_func_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         cnt_q       <= cnt_d;
         act_q       <= act_d;
      end
   end

   assign o_rsps_stb      = rsps_stb_q;
   assign o_rsps          = rsps_q;
   assign o_rsps_len      = 8'd40;
   assign o_rsps_fail     = rsps_fail_q;
   assign o_data_activate = act_q;
   assign o_write_flag    = wflag_q;
   assign o_data_count    = dcount_q;
   assign o_reg_stb       = reg_stb_q;
   assign o_reg_write     = reg_write_q;
   assign o_reg_func      = reg_func_q;
   assign o_reg_addr      = reg_addr_q;
   assign o_reg_wdata     = reg_wdata_q;
   assign o_card_state    = card_q;
   assign o_rca           = rca_q;
   assign o_crc_err_count = crc_cnt_q;

endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// tb/tb_sdio_cmd_sequencer.sv - directed self-checking bench for sdio_cmd_sequencer with an event-queue card model
module tb_sdio_cmd_sequencer;

   localparam logic [15:0] RCA_DEF = 16'h0001;
   localparam logic [2:0]  NFUNC   = 3'd1;
   localparam logic [7:0]  RTO     = 8'd64;
   localparam logic [23:0] OCR     = 24'hFF8000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_cmd_stb, i_cmd_crc_good_stb;
   logic [5:0]  i_cmd;
   logic [31:0] i_cmd_arg;
   logic        i_rsps_idle;
   logic        o_rsps_stb;
   logic [39:0] o_rsps;
   logic [7:0]  o_rsps_len;
   logic        o_rsps_fail;
   logic        o_data_activate;
   logic        i_data_finished;
   logic        o_write_flag;
   logic [12:0] o_data_count;
   logic        o_reg_stb, o_reg_write;
   logic [2:0]  o_reg_func;
   logic [16:0] o_reg_addr;
   logic [7:0]  o_reg_wdata;
   logic        i_reg_ack;
   logic [7:0]  i_reg_rdata;
   logic [23:0] i_ocr;
   logic [1:0]  o_card_state;
   logic [15:0] o_rca;
   logic [7:0]  o_crc_err_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          is_fail;
      logic [39:0] val;
   } ev_t;
   ev_t exp_q[$];
   ev_t cev;

   logic [1:0]  m_state;
   logic [15:0] m_rca;
   logic [7:0]  m_crc;
   logic [12:0] m_dcount;
   logic        m_wflag;

   sdio_cmd_sequencer #(.DEFAULT_RCA(RCA_DEF), .NUM_FUNCS(NFUNC), .REG_TIMEOUT(RTO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cmd_stb(i_cmd_stb), .i_cmd_crc_good_stb(i_cmd_crc_good_stb),
      .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_rsps_idle(i_rsps_idle),
      .o_rsps_stb(o_rsps_stb), .o_rsps(o_rsps), .o_rsps_len(o_rsps_len), .o_rsps_fail(o_rsps_fail),
      .o_data_activate(o_data_activate), .i_data_finished(i_data_finished),
      .o_write_flag(o_write_flag), .o_data_count(o_data_count),
      .o_reg_stb(o_reg_stb), .o_reg_write(o_reg_write), .o_reg_func(o_reg_func),
      .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
      .i_reg_ack(i_reg_ack), .i_reg_rdata(i_reg_rdata), .i_ocr(i_ocr),
      .o_card_state(o_card_state), .o_rca(o_rca), .o_crc_err_count(o_crc_err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_rsp(input logic [5:0] idx, input logic [31:0] a);
      ev_t e;
      e.is_fail = 1'b0;
      e.val     = {2'b00, idx, a};
      exp_q.push_back(e);
   endtask

   task automatic push_fail();
      ev_t e;
      e.is_fail = 1'b1;
      e.val     = 40'd0;
      exp_q.push_back(e);
   endtask

   // Card-level model: what a command must produce given the card's current state
   task automatic model_cmd(input logic [5:0] idx, input logic [31:0] a, input bit good,
                            input bit timed_out, input logic [7:0] rd);
      bit xfer;
      xfer = (m_state == 2'd2);
      if (!good) begin
         if (m_crc != 8'd255) m_crc = m_crc + 8'd1;
         push_fail();
      end else if (idx == 6'd0) begin
         m_state = 2'd0;
         m_rca   = 16'd0;
         push_fail();
      end else if (idx == 6'd5) begin
         push_rsp(6'h3F, 32'h8000_0000 | (32'(NFUNC) << 28) | 32'(OCR));
      end else if (idx == 6'd3 && !xfer) begin
         m_rca   = RCA_DEF;
         m_state = 2'd1;
         push_rsp(6'd3, 32'(RCA_DEF) << 16);
      end else if (idx == 6'd7) begin
         if (a[31:16] == m_rca && m_rca != 16'd0) begin
            m_state = 2'd2;
            push_rsp(6'd7, 32'd4 * 32'd512);
         end else begin
            m_state = 2'd1;
            push_fail();
         end
      end else if (idx == 6'd52 && xfer) begin
         push_rsp(6'd52, timed_out ? 32'h0000_2800 : 32'h0000_2000 + 32'(rd));
      end else if (idx == 6'd53 && xfer) begin
         if (a[27]) begin
            push_rsp(6'd53, 32'h0000_4000);
         end else begin
            m_dcount = (a[8:0] == 9'd0) ? 13'd512 : 13'(a[8:0]);
            m_wflag  = a[31];
            push_rsp(6'd53, 32'h0000_2000);
         end
      end else begin
         push_fail();
      end
   endtask

   task automatic send(input logic [5:0] idx, input logic [31:0] a, input bit good);
      @(posedge clk); #1;
      i_cmd_stb          = 1'b1;
      i_cmd_crc_good_stb = good;
      i_cmd              = idx;
      i_cmd_arg          = a;
      @(posedge clk); #1;
      i_cmd_stb          = 1'b0;
      i_cmd_crc_good_stb = 1'b0;
   endtask

   task automatic issue(input logic [5:0] idx, input logic [31:0] a, input bit good,
                        input bit timed_out, input logic [7:0] rd);
      model_cmd(idx, a, good, timed_out, rd);
      send(idx, a, good);
   endtask

   task automatic expect_rsp(input string name, input logic [39:0] lit);
      @(negedge clk);
      chk({name, "_decode_cycle"}, 40'(o_rsps_stb), 40'd0);
      @(negedge clk);
      chk({name, "_latency"}, 40'(o_rsps_stb), 40'd1);
      chk({name, "_value"}, o_rsps, lit);
   endtask

   task automatic expect_fail(input string name);
      @(negedge clk);
      chk({name, "_decode_cycle"}, 40'(o_rsps_fail), 40'd0);
      @(negedge clk);
      chk({name, "_fail"}, 40'(o_rsps_fail), 40'd1);
   endtask

   task automatic settle(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_drain"}, 40'(exp_q.size()), 40'd0);
      repeat (2) @(negedge clk);
      chk({tag, "_card_state"}, 40'(o_card_state), 40'(m_state));
      chk({tag, "_rca"}, 40'(o_rca), 40'(m_rca));
      chk({tag, "_crc_count"}, 40'(o_crc_err_count), 40'(m_crc));
      chk({tag, "_data_count"}, 40'(o_data_count), 40'(m_dcount));
      chk({tag, "_write_flag"}, 40'(o_write_flag), 40'(m_wflag));
   endtask

   task automatic model_reset();
      m_state  = 2'd0;
      m_rca    = 16'd0;
      m_crc    = 8'd0;
      m_dcount = 13'd0;
      m_wflag  = 1'b0;
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_rsps_stb) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 40'(o_rsps_stb), 40'd0);
            end else begin
               cev = exp_q.pop_front();
               if (cev.is_fail) chk("rsp_where_fail_due", 40'(o_rsps_stb), 40'd0);
               else             chk("rsp_model", o_rsps, cev.val);
            end
         end
         if (o_rsps_fail) begin
            if (exp_q.size() == 0) begin
               chk("fail_unexpected", 40'(o_rsps_fail), 40'd0);
            end else begin
               cev = exp_q.pop_front();
               if (!cev.is_fail) chk("fail_where_rsp_due", 40'(o_rsps_fail), 40'd0);
               else              chk("fail_alone", 40'(o_rsps_stb), 40'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0;
      i_cmd_stb = 1'b0; i_cmd_crc_good_stb = 1'b0; i_cmd = 6'd0; i_cmd_arg = 32'd0;
      i_rsps_idle = 1'b1; i_data_finished = 1'b0;
      i_reg_ack = 1'b0; i_reg_rdata = 8'd0; i_ocr = OCR;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_rsps_stb", 40'(o_rsps_stb), 40'd0);
      chk("rst_rsps", o_rsps, 40'd0);
      chk("rst_rsps_len", 40'(o_rsps_len), 40'd40);
      chk("rst_rsps_fail", 40'(o_rsps_fail), 40'd0);
      chk("rst_activate", 40'(o_data_activate), 40'd0);
      chk("rst_reg_stb", 40'(o_reg_stb), 40'd0);
      chk("rst_card_state", 40'(o_card_state), 40'd0);
      chk("rst_rca", 40'(o_rca), 40'd0);
      chk("rst_crc", 40'(o_crc_err_count), 40'd0);
      chk("rst_data_count", 40'(o_data_count), 40'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) begin
         issue(6'd8, 32'h0000_01AA, 1'b0, 1'b0, 8'd0);
         @(negedge clk);
         chk("badcrc_fail_next_cycle", 40'(o_rsps_fail), 40'd1);
      end
      settle("badcrc");
      chk("badcrc_count_lit", 40'(o_crc_err_count), 40'd3);

      issue(6'd52, 32'h0000_0400, 1'b1, 1'b0, 8'd0);
      expect_fail("cmd52_in_init");
      settle("cmd52_in_init");

      issue(6'd5, 32'd0, 1'b1, 1'b0, 8'd0);
      expect_rsp("cmd5", 40'h3F_90FF_8000);
      settle("cmd5");

      issue(6'd3, 32'd0, 1'b1, 1'b0, 8'd0);
      expect_rsp("cmd3", 40'h03_0001_0000);
      settle("cmd3");
      chk("cmd3_stby_lit", 40'(o_card_state), 40'd1);

      issue(6'd7, 32'h0002_0000, 1'b1, 1'b0, 8'd0);
      expect_fail("cmd7_wrong_rca");
      settle("cmd7_wrong_rca");

      issue(6'd7, 32'h0001_0000, 1'b1, 1'b0, 8'd0);
      expect_rsp("cmd7", 40'h07_0000_0800);
      settle("cmd7");
      chk("cmd7_xfer_lit", 40'(o_card_state), 40'd2);

      issue(6'd52, 32'h0000_0400, 1'b1, 1'b0, 8'h5A);
      @(negedge clk);
      chk("rd52_reg_stb_early", 40'(o_reg_stb), 40'd0);
      @(negedge clk);
      chk("rd52_reg_stb", 40'(o_reg_stb), 40'd1);
      chk("rd52_reg_addr", 40'(o_reg_addr), 40'h00002);
      chk("rd52_reg_write", 40'(o_reg_write), 40'd0);
      chk("rd52_reg_func", 40'(o_reg_func), 40'd0);
      repeat (5) @(posedge clk);
      #1; i_reg_ack = 1'b1; i_reg_rdata = 8'h5A;
      @(posedge clk); #1; i_reg_ack = 1'b0;
      @(negedge clk);
      chk("rd52_rsp_after_ack", 40'(o_rsps_stb), 40'd1);
      chk("rd52_rsp_lit", o_rsps, 40'h34_0000_205A);
      settle("rd52");

      issue(6'd52, 32'h93FF_FEA5, 1'b1, 1'b0, 8'h77);
      repeat (2) @(negedge clk);
      chk("wr52_reg_stb", 40'(o_reg_stb), 40'd1);
      chk("wr52_reg_write", 40'(o_reg_write), 40'd1);
      chk("wr52_reg_func", 40'(o_reg_func), 40'd1);
      chk("wr52_reg_addr", 40'(o_reg_addr), 40'h1FFFF);
      chk("wr52_reg_wdata", 40'(o_reg_wdata), 40'hA5);
      repeat (64) @(posedge clk);
      #1; i_reg_ack = 1'b1; i_reg_rdata = 8'h77;
      @(posedge clk); #1; i_reg_ack = 1'b0;
      @(negedge clk);
      chk("ack_vs_timeout_stb", 40'(o_rsps_stb), 40'd1);
      chk("ack_vs_timeout_rsp", o_rsps, 40'h34_0000_2077);
      settle("ack_vs_timeout");

      issue(6'd52, 32'h0000_0400, 1'b1, 1'b1, 8'd0);
      repeat (2) @(negedge clk);
      chk("to52_reg_stb", 40'(o_reg_stb), 40'd1);
      @(negedge clk);
      chk("to52_reg_stb_pulse", 40'(o_reg_stb), 40'd0);
      k = 1;
      while (!o_rsps_stb && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("to52_latency", 40'(k), 40'(RTO) + 40'd1);
      chk("to52_rsp_lit", o_rsps, 40'h34_0000_2800);
      settle("to52");

      issue(6'd3, 32'd0, 1'b1, 1'b0, 8'd0);
      expect_fail("cmd3_in_xfer");
      settle("cmd3_in_xfer");

      issue(6'd8, 32'h0000_01AA, 1'b1, 1'b0, 8'd0);
      expect_fail("cmd8_illegal");
      settle("cmd8_illegal");

      i_rsps_idle = 1'b0;
      issue(6'd53, 32'h9000_0000, 1'b1, 1'b0, 8'd0);
      expect_rsp("wr53", 40'h35_0000_2000);
      repeat (3) @(negedge clk);
      chk("wr53_wait_idle", 40'(o_data_activate), 40'd0);
      chk("wr53_count_lit", 40'(o_data_count), 40'd512);
      chk("wr53_wflag_lit", 40'(o_write_flag), 40'd1);
      @(posedge clk); #1; i_rsps_idle = 1'b1;
      @(negedge clk);
      chk("wr53_act_before_sample", 40'(o_data_activate), 40'd0);
      @(negedge clk);
      chk("wr53_act_rise", 40'(o_data_activate), 40'd1);
      send(6'd52, 32'h0000_0400, 1'b0);
      @(negedge clk);
      chk("wr53_cmd_ignored_act", 40'(o_data_activate), 40'd1);
      chk("wr53_cmd_ignored_crc", 40'(o_crc_err_count), 40'(m_crc));
      @(posedge clk); #1; i_data_finished = 1'b1;
      @(negedge clk);
      chk("wr53_act_hold", 40'(o_data_activate), 40'd1);
      @(posedge clk); #1; i_data_finished = 1'b0;
      @(negedge clk);
      chk("wr53_act_fall", 40'(o_data_activate), 40'd0);
      settle("wr53");

      issue(6'd53, 32'h0800_0004, 1'b1, 1'b0, 8'd0);
      expect_rsp("blk53", 40'h35_0000_4000);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("blk53_no_act", 40'(o_data_activate), 40'd0);
      end
      settle("blk53");

      issue(6'd53, 32'h0000_0008, 1'b1, 1'b0, 8'd0);
      expect_rsp("rd53", 40'h35_0000_2000);
      @(negedge clk);
      @(negedge clk);
      chk("rd53_act", 40'(o_data_activate), 40'd1);
      chk("rd53_count", 40'(o_data_count), 40'd8);
      chk("rd53_wflag", 40'(o_write_flag), 40'd0);
      #2; rst_n = 1'b0;
      #1;
      chk("async_rst_act", 40'(o_data_activate), 40'd0);
      chk("async_rst_state", 40'(o_card_state), 40'd0);
      chk("async_rst_rca", 40'(o_rca), 40'd0);
      chk("async_rst_count", 40'(o_data_count), 40'd0);
      model_reset();
      @(posedge clk); #1; rst_n = 1'b1;

      issue(6'd5, 32'd0, 1'b1, 1'b0, 8'd0);
      expect_rsp("post_rst_cmd5", 40'h3F_90FF_8000);
      settle("post_rst_cmd5");
      issue(6'd3, 32'd0, 1'b1, 1'b0, 8'd0);
      expect_rsp("post_rst_cmd3", 40'h03_0001_0000);
      settle("post_rst_cmd3");
      issue(6'd0, 32'd0, 1'b1, 1'b0, 8'd0);
      expect_fail("cmd0");
      settle("cmd0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdio_cmd_sequencer.md
Name: sdio_cmd_sequencer

Overview:
- Command-layer controller that sits directly above the SDIO device PHY's command path.
- Consumes decoded commands (index, argument, CRC-good strobe) from the PHY and tracks card state and RCA.
- Performs CMD52 register accesses through a simple register-bus handshake, builds the 40-bit response word for the PHY, and activates the data PHY for CMD53 transfers.
- Drops bad-CRC or illegal commands by pulsing the PHY's response-fail input.

Parameters:
- DEFAULT_RCA, 16'h0001, RCA published on CMD3.
- NUM_FUNCS, 3'd1, number of I/O functions reported in the R4 response.
- REG_TIMEOUT, 8'd64, cycles to wait for i_reg_ack after o_reg_stb.

Ports:
- clk  in  1  SDIO clock, shared with the PHY.
- rst_n  in  1  reset; asynchronous, active-low.
- i_cmd_stb  in  1  command received (one-cycle pulse from PHY).
- i_cmd_crc_good_stb  in  1  CRC good; same cycle as i_cmd_stb.
- i_cmd  in  6  command index.
- i_cmd_arg  in  32  command argument.
- i_rsps_idle  in  1  PHY command path idle.
- o_rsps_stb  out  1  response valid, one-cycle pulse.
- o_rsps  out  40  {1'b0 start, 1'b0 dir, index[5:0], arg[31:0]}.
- o_rsps_len  out  8  response bit count, always 8'd40.
- o_rsps_fail  out  1  one-cycle pulse: abandon response.
- o_data_activate  out  1  level; start the data PHY.
- i_data_finished  in  1  data PHY done.
- o_write_flag  out  1  CMD53 arg[31] (R/W).
- o_data_count  out  13  CMD53 byte count.
- o_reg_stb  out  1  register access request pulse.
- o_reg_write  out  1  1 = write.
- o_reg_func  out  3  function number.
- o_reg_addr  out  17  register address.
- o_reg_wdata  out  8  write data.
- i_reg_ack  in  1  access complete.
- i_reg_rdata  in  8  read data, valid with ack.
- i_ocr  in  24  OCR value reported in R4.
- o_card_state  out  2  0 INIT, 1 STBY, 2 CMD (transfer).
- o_rca  out  16  current RCA.
- o_crc_err_count  out  8  saturating count of bad-CRC commands.

Behaviour:
- Reset (async, rst_n low): all outputs 0; card state INIT; o_rca 0; o_rsps_len 8'd40; FSM in IDLE.

FSM states:
- IDLE
  - Samples i_cmd_stb.
  - If i_cmd_crc_good_stb is low in the same cycle: pulse o_rsps_fail next cycle, increment o_crc_err_count (saturates at 8'hFF), stay in IDLE.
  - Otherwise latch index/arg and go to DECODE.
- DECODE (one cycle), by index:
  - CMD0: card state -> INIT, rca -> 0, o_rsps_fail, go to IDLE.
  - CMD5: R4 response, index 6'h3F, arg = {1'b1, NUM_FUNCS, 1'b0, 3'b0, i_ocr}. Go to RESPOND.
  - CMD3 (state INIT or STBY): rca <= DEFAULT_RCA, state -> STBY. R6 response, arg = {DEFAULT_RCA, 16'h0000}. Go to RESPOND.
  - CMD7:
    - arg[31:16] == rca and rca != 0: state -> CMD; R1b response, arg = {19'b0, 4'd4, 9'b0}; go to RESPOND.
    - Otherwise: state -> STBY, o_rsps_fail, go to IDLE.
  - CMD52 (state CMD only): drive o_reg_* from the argument:
    - write = arg[31]
    - func = arg[30:28]
    - addr = arg[25:9]
    - wdata = arg[7:0]
    - Pulse o_reg_stb, go to REG_WAIT.
  - CMD53 (state CMD only):
    - arg[27] (block mode) = 1: R5 response, flags = 8'h40 (ILLEGAL_COMMAND).
    - Otherwise: o_data_count = (arg[8:0] == 0) ? 13'd512 : arg[8:0]; o_write_flag = arg[31]; R5 response, flags = 8'h20, data 0; mark data pending.
    - Go to RESPOND.
  - Any other index, or CMD52/CMD53 outside state CMD: o_rsps_fail, go to IDLE.
- REG_WAIT
  - Counter starts at 0 and increments each cycle.
  - i_reg_ack seen: R5 response, flags 8'h20, data = i_reg_rdata (write: echo i_reg_rdata), go to RESPOND.
  - Counter reaches REG_TIMEOUT-1 without ack: R5 flags 8'h28 (ERROR), data 8'h00, go to RESPOND.
  - Ack and timeout in the same cycle: ack wins.
- RESPOND
  - o_rsps valid; pulse o_rsps_stb for one cycle.
  - Go to RSP_WAIT.
- RSP_WAIT
  - Wait for i_rsps_idle high.
  - Data pending: go to DATA. Else: go to IDLE.
- DATA
  - o_data_activate high until i_data_finished is sampled high; then deassert and go to IDLE.

R5 response layout:
- index = command index.
- arg = {16'h0, flags, data}.

Latency:
- i_cmd_stb in cycle N -> DECODE in N+1 -> o_rsps_stb in N+2 for non-register commands.
- CMD52: o_reg_stb in N+2; o_rsps_stb the cycle after ack is sampled.

Boundary conditions:
- i_cmd_stb while not in IDLE is ignored and not counted, including during DATA.
- rst_n asserted mid-transaction aborts immediately; o_data_activate and o_reg_stb drop asynchronously.
- o_rsps, o_data_count and o_write_flag hold their value until the next command is decoded.

Test Plan:
- Bad CRC: cmd_stb with crc_good=0 three times -> three o_rsps_fail pulses, o_crc_err_count=3, no o_rsps_stb.
- Init sequence:
  - CMD5 -> o_rsps=40'h3F_9000_0000 | {16'h0, i_ocr} with i_ocr=24'hFF8000.
  - CMD3 -> o_rsps arg 32'h0001_0000, state STBY.
  - CMD7 arg 32'h0001_0000 -> state CMD, arg 32'h0000_0800.
- CMD52 read: arg 32'h0000_0400 (func0, addr 0x0002); ack after 5 cycles with rdata 8'h5A -> o_reg_addr=17'h00002, o_rsps=40'h34_0000_205A.
- CMD52 with ack never returned -> o_rsps_stb exactly REG_TIMEOUT+1 cycles after o_reg_stb, arg 32'h0000_2800.
- CMD53:
  - Byte-mode write, count 0 -> response flags 8'h20, o_data_count=512, o_write_flag=1; o_data_activate rises after i_rsps_idle, falls the cycle after i_data_finished.
  - Block-mode -> flags 8'h40, no activate.
- Illegal/state: CMD52 while in INIT -> o_rsps_fail. Async reset during DATA -> o_data_activate=0 immediately, state INIT, rca 0.
